// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with trap/interrupt sequencing and performance counters
module csr_trap_unit #(
  parameter int XLEN = 64,
  parameter int NUM_HPM = 4,
  parameter bit VECTORED_EN = 1,
  parameter logic [XLEN-1:0] RESET_MTVEC = 'h8000_0000,
  parameter logic [XLEN-1:0] HART_ID = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [11:0]                           rd_addr,
  output logic [XLEN-1:0]                       rd_data,
  output logic                                  rd_illegal,
  input  logic                                  cmt_valid,
  input  logic [XLEN-1:0]                       cmt_pc,
  input  logic [2:0]                            cmt_cmd,
  input  logic [11:0]                           cmt_addr,
  input  logic [XLEN-1:0]                       cmt_wdata,
  input  logic                                  cmt_ex,
  input  logic [3:0]                            cmt_ex_code,
  input  logic [XLEN-1:0]                       cmt_tval,
  input  logic                                  cmt_retire,
  input  logic                                  stall,
  input  logic                                  trint,
  input  logic                                  swint,
  input  logic                                  exint,
  input  logic [(NUM_HPM < 1 ? 1 : NUM_HPM)-1:0] hpm_event,
  output logic                                  redirect_valid,
  output logic [XLEN-1:0]                       redirect_pc,
  output logic                                  int_pending,
  output logic [1:0]                            priv
);
  localparam int NH = NUM_HPM < 1 ? 1 : NUM_HPM;
  localparam logic [63:0] IH_MASK64 = ((64'd1 << (3 + NUM_HPM)) - 64'd1) & ~64'd2;
  localparam logic [XLEN-1:0] IH_MASK = XLEN'(IH_MASK64);
  localparam logic [XLEN-1:0] TV_MASK = ~(VECTORED_EN ? XLEN'(2) : XLEN'(3));
  localparam logic [XLEN-1:0] IE_MASK = XLEN'(12'h888);

  logic st_mie, st_mpie, msip, mtip, meip;
  logic [1:0] st_mpp;
  logic [XLEN-1:0] mstatus, mip, mie_r, mtvec, mcountinhibit, mscratch, mepc, mcause, mtval;
  logic [XLEN-1:0] mcycle, minstret, old, nval, tbase, tvec, next_pc;
  logic [XLEN-1:0] hpm [NH];
  logic [XLEN-1:0] pend;
  logic [3:0] int_code;
  logic cmt_ill, act, take_int, take_ex, take_trap, do_mret, do_csr, do_wr;

  always_comb begin
    mstatus = '0;
    mstatus[3] = st_mie;
    mstatus[7] = st_mpie;
    mstatus[12:11] = st_mpp;
    mip = '0;
    mip[3] = msip;
    mip[7] = mtip;
    mip[11] = meip;
  end

  // MSB of the result flags an unimplemented address
  function automatic logic [XLEN:0] csr_rd(input logic [11:0] a);
    logic [XLEN:0] r;
    r = '0;
    case (a)
      12'h300: r[XLEN-1:0] = mstatus;
      12'h301: ;
      12'h304: r[XLEN-1:0] = mie_r;
      12'h305: r[XLEN-1:0] = mtvec;
      12'h320: r[XLEN-1:0] = mcountinhibit;
      12'h340: r[XLEN-1:0] = mscratch;
      12'h341: r[XLEN-1:0] = mepc;
      12'h342: r[XLEN-1:0] = mcause;
      12'h343: r[XLEN-1:0] = mtval;
      12'h344: r[XLEN-1:0] = mip;
      12'hB00: r[XLEN-1:0] = mcycle;
      12'hB02: r[XLEN-1:0] = minstret;
      12'hF14: r[XLEN-1:0] = HART_ID;
      default: begin
        r[XLEN] = 1'b1;
        for (int i = 0; i < NUM_HPM; i++) if (a == 12'hB03 + 12'(i)) r = {1'b0, hpm[i]};
      end
    endcase
    return r;
  endfunction

  always_comb begin
    {rd_illegal, rd_data} = csr_rd(rd_addr);
    {cmt_ill, old} = csr_rd(cmt_addr);
  end

  assign pend = mie_r & mip;
  assign int_pending = st_mie & |pend;
  assign int_code = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
  assign act = cmt_valid & !stall;
  assign take_int = act & int_pending;
  assign take_ex = act & !int_pending & cmt_ex;
  assign take_trap = take_int | take_ex;
  assign do_mret = act & !int_pending & !cmt_ex & (cmt_cmd == 3'd4);
  assign do_csr = act & !int_pending & !cmt_ex & (cmt_cmd inside {3'd1, 3'd2, 3'd3});
  assign nval = cmt_cmd == 3'd1 ? cmt_wdata : cmt_cmd == 3'd2 ? old | cmt_wdata : old & ~cmt_wdata;
  assign do_wr = do_csr & !cmt_ill & !(cmt_addr inside {12'h301, 12'h344, 12'hF14})
               & (cmt_cmd == 3'd1 | |cmt_wdata);
  assign tbase = {mtvec[XLEN-1:2], 2'b00};
  assign tvec = take_int & mtvec[0] ? tbase + XLEN'({int_code, 2'b00}) : tbase;
  assign next_pc = take_trap ? tvec : do_mret ? mepc : cmt_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      priv <= 2'd3;
      {st_mie, st_mpie, st_mpp, msip, mtip, meip} <= '0;
      {mie_r, mcountinhibit, mscratch, mepc, mcause, mtval, mcycle, minstret} <= '0;
      mtvec <= RESET_MTVEC & TV_MASK;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      for (int i = 0; i < NH; i++) hpm[i] <= '0;
    end else begin
      {meip, mtip, msip} <= {exint, trint, swint};
      redirect_valid <= take_trap | do_mret | do_csr;
      redirect_pc <= next_pc;
      if (!mcountinhibit[0]) mcycle <= mcycle + XLEN'(1);
      if (act & cmt_retire & !take_trap & !mcountinhibit[2]) minstret <= minstret + XLEN'(1);
      for (int i = 0; i < NUM_HPM; i++)
        if (hpm_event[i] & !mcountinhibit[3+i]) hpm[i] <= hpm[i] + XLEN'(1);
      if (take_trap) begin
        mepc <= cmt_pc & ~XLEN'(3);
        mcause <= take_int ? {1'b1, {(XLEN-5){1'b0}}, int_code} : {{(XLEN-4){1'b0}}, cmt_ex_code};
        mtval <= take_int ? '0 : cmt_tval;
        st_mpie <= st_mie;
        st_mie <= 1'b0;
        st_mpp <= priv;
        priv <= 2'd3;
      end else if (do_mret) begin
        st_mie <= st_mpie;
        st_mpie <= 1'b1;
        priv <= st_mpp;
        st_mpp <= 2'd0;
      end else if (do_wr) begin
        case (cmt_addr)
          12'h300: begin
            st_mie <= nval[3];
            st_mpie <= nval[7];
            st_mpp <= {2{&nval[12:11]}};
          end
          12'h304: mie_r <= nval & IE_MASK;
          12'h305: mtvec <= nval & TV_MASK;
          12'h320: mcountinhibit <= nval & IH_MASK;
          12'h340: mscratch <= nval;
          12'h341: mepc <= nval & ~XLEN'(3);
          12'h342: mcause <= nval;
          12'h343: mtval <= nval;
          12'hB00: mcycle <= nval;
          12'hB02: minstret <= nval;
          default: for (int i = 0; i < NUM_HPM; i++) if (cmt_addr == 12'hB03 + 12'(i)) hpm[i] <= nval;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: scoreboard bench for csr_trap_unit with default parameters
module tb_csr_trap_unit;
  logic clk = 0, reset = 1;
  logic [11:0] rd_addr = '0, cmt_addr = '0;
  logic [63:0] rd_data, cmt_pc = '0, cmt_wdata = '0, cmt_tval = '0, redirect_pc, pre_rd;
  logic rd_illegal, cmt_valid = 0, cmt_ex = 0, cmt_retire = 0, stall = 0;
  logic trint = 0, swint = 0, exint = 0, redirect_valid, int_pending;
  logic [2:0] cmt_cmd = '0;
  logic [3:0] cmt_ex_code = '0, hpm_event = '0;
  logic [1:0] priv;
  logic [63:0] rdq[$], expq[$];
  int n_vec = 0, n_bad = 0, exp_ret = 0;

  csr_trap_unit dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_illegal(rd_illegal),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_cmd(cmt_cmd), .cmt_addr(cmt_addr),
    .cmt_wdata(cmt_wdata), .cmt_ex(cmt_ex), .cmt_ex_code(cmt_ex_code), .cmt_tval(cmt_tval),
    .cmt_retire(cmt_retire), .stall(stall), .trint(trint), .swint(swint), .exint(exint),
    .hpm_event(hpm_event), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .int_pending(int_pending), .priv(priv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // every redirect must be announced by the cycle that committed it, and vice versa
  always @(negedge clk) if (rdq.size() > 0 || redirect_valid) begin
    chk("redir_valid", 64'(redirect_valid), 64'(rdq.size() > 0));
    if (rdq.size() > 0) chk("redir_pc", redirect_pc, rdq.pop_front());
  end

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input bit ill, input string tag);
    expq.push_back(exp);
    rd_addr = a;
    @(negedge clk);
    chk(tag, rd_data, expq.pop_front());
    chk({tag, "_ill"}, 64'(rd_illegal), 64'(ill));
  endtask

  task automatic commit(input logic [2:0] cmd, input logic [11:0] a, input logic [63:0] wd,
                        input logic [63:0] pc, input bit redir, input logic [63:0] tgt, input bit ret);
    cmt_valid = 1; cmt_cmd = cmd; cmt_addr = a; cmt_wdata = wd; cmt_pc = pc; cmt_retire = 1;
    #1 pre_rd = rd_data;
    @(posedge clk);
    if (redir) rdq.push_back(tgt);
    exp_ret += int'(ret);
    #1 cmt_valid = 0; cmt_cmd = 0; cmt_retire = 0;
  endtask

  initial begin
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;
    chk("rst_priv", 64'(priv), 64'd3);
    chk("rst_redir", 64'(redirect_valid), 64'd0);
    chk("rst_intp", 64'(int_pending), 64'd0);
    rd(12'h305, 64'h8000_0000, 0, "rst_mtvec");
    rd(12'hF14, 64'd0, 0, "hartid");
    rd(12'h123, 64'd0, 1, "unimpl");
    rd(12'h300, 64'd0, 0, "rst_mstatus");

    commit(3'd1, 12'h341, 64'h1003, 64'h100, 1, 64'h104, 1);
    rd(12'h341, 64'h1000, 0, "mepc_align");
    commit(3'd2, 12'h300, 64'h1888, 64'h104, 1, 64'h108, 1);
    rd(12'h300, 64'h1888, 0, "mstatus_rs");
    commit(3'd3, 12'h300, 64'h1000, 64'h108, 1, 64'h10C, 1);
    rd(12'h300, 64'h0088, 0, "mpp_warl");
    rd_addr = 12'h340;
    commit(3'd1, 12'h340, 64'h55, 64'h10C, 1, 64'h110, 1);
    chk("same_cycle_pre", pre_rd, 64'd0);
    rd(12'h340, 64'h55, 0, "mscratch");
    commit(3'd1, 12'h305, 64'h8000_0003, 64'h110, 1, 64'h114, 1);
    rd(12'h305, 64'h8000_0001, 0, "mtvec_mask");
    commit(3'd1, 12'h304, 64'hFFF, 64'h114, 1, 64'h118, 1);
    rd(12'h304, 64'h888, 0, "mie_mask");
    commit(3'd1, 12'h304, 64'h880, 64'h118, 1, 64'h11C, 1);
    rd(12'h304, 64'h880, 0, "mie");
    swint = 1;
    rd(12'h344, 64'h8, 0, "mip_msip");
    chk("intp_masked", 64'(int_pending), 64'd0);
    commit(3'd1, 12'h344, 64'h0, 64'h11C, 1, 64'h120, 1);
    rd(12'h344, 64'h8, 0, "mip_ro");
    swint = 0;

    exint = 1; trint = 1;
    @(negedge clk);
    chk("intp", 64'(int_pending), 64'd1);
    commit(3'd1, 12'h340, 64'h77, 64'h200, 1, 64'h8000_002C, 0);
    exint = 0; trint = 0;
    rd(12'h342, 64'h8000_0000_0000_000B, 0, "int_mcause");
    rd(12'h341, 64'h200, 0, "int_mepc");
    rd(12'h343, 64'h0, 0, "int_mtval");
    rd(12'h300, 64'h1880, 0, "int_mstatus");
    rd(12'h340, 64'h55, 0, "int_suppress");
    chk("int_priv", 64'(priv), 64'd3);

    cmt_valid = 1; cmt_ex = 1; cmt_ex_code = 4'd2; cmt_pc = 64'h40; cmt_tval = 64'hDEAD;
    cmt_retire = 0; stall = 1;
    rd(12'h341, 64'h200, 0, "stall_mepc");
    rd(12'h342, 64'h8000_0000_0000_000B, 0, "stall_mcause");
    stall = 0;
    @(posedge clk);
    rdq.push_back(64'h8000_0000);
    #1 cmt_valid = 0; cmt_ex = 0;
    rd(12'h341, 64'h40, 0, "ex_mepc");
    rd(12'h342, 64'h2, 0, "ex_mcause");
    rd(12'h343, 64'hDEAD, 0, "ex_mtval");
    rd(12'h300, 64'h1800, 0, "ex_mstatus");

    commit(3'd1, 12'h300, 64'h80, 64'h8000_0000, 1, 64'h8000_0004, 1);
    rd(12'h300, 64'h80, 0, "pre_mret");
    commit(3'd4, 12'h000, 64'h0, 64'h8000_0004, 1, 64'h40, 1);
    chk("mret_priv", 64'(priv), 64'd0);
    rd(12'h300, 64'h88, 0, "mret_mstatus");
    rd(12'hB02, 64'(exp_ret), 0, "minstret");

    commit(3'd1, 12'h320, 64'hFF, 64'h44, 1, 64'h48, 0);
    rd(12'h320, 64'h7D, 0, "inhibit_mask");
    commit(3'd1, 12'h320, 64'h5, 64'h48, 1, 64'h4C, 0);
    rd(12'h320, 64'h5, 0, "inhibit");
    commit(3'd1, 12'hB00, '1, 64'h4C, 1, 64'h50, 0);
    commit(3'd1, 12'hB02, 64'd100, 64'h50, 1, 64'h54, 0);
    hpm_event = 4'b0001;
    for (int i = 0; i < 10; i++) commit(3'd0, 12'h000, 64'h0, 64'h54 + 64'(4 * i), 0, 64'h0, 0);
    hpm_event = 4'b0000;
    rd(12'hB00, '1, 0, "mcycle_frozen");
    rd(12'hB02, 64'd100, 0, "minstret_frozen");
    rd(12'hB03, 64'd10, 0, "hpm3");
    rd(12'hB04, 64'd0, 0, "hpm4");
    commit(3'd1, 12'h320, 64'h0, 64'h80, 1, 64'h84, 0);
    rd(12'hB00, '1, 0, "mcycle_last");
    rd(12'hB00, 64'd0, 0, "mcycle_wrap");
    rd(12'hB02, 64'd100, 0, "minstret_held");
    commit(3'd1, 12'hB00, 64'd50, 64'h84, 1, 64'h88, 0);
    rd(12'hB00, 64'd50, 0, "mcycle_wr_wins");
    rd(12'hB02, 64'd101, 0, "minstret_resume");

    cmt_valid = 1; cmt_ex = 1; cmt_ex_code = 4'd5; cmt_pc = 64'h300; reset = 1;
    @(posedge clk);
    #1 reset = 0; cmt_valid = 0; cmt_ex = 0;
    @(negedge clk);
    chk("rst_trap_redir", 64'(redirect_valid), 64'd0);
    chk("rst_trap_priv", 64'(priv), 64'd3);
    rd(12'h341, 64'd0, 0, "rst_trap_mepc");
    rd(12'h305, 64'h8000_0000, 0, "rst_trap_mtvec");
    chk("redir_left", 64'(rdq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file with integrated trap/interrupt sequencer and performance counters.
- Sits at the commit (M→W) boundary of the pipeline.
- Provides a combinational CSR read port for decode.
- Commits CSR writes, exceptions, interrupts and MRET, and drives a one-cycle PC redirect to fetch.

Parameters:
XLEN, 64, register width (32 or 64)
NUM_HPM, 4, number of mhpmcounter3..(3+NUM_HPM-1), range 0..29
VECTORED_EN, 1, 1 = mtvec mode 1 (vectored) is legal; 0 = mtvec[1:0] reads 0
RESET_MTVEC, 'h8000_0000, mtvec reset value
HART_ID, 0, value returned by mhartid

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rd_addr  in  12  CSR read address (decode)
rd_data  out  XLEN  current CSR value, combinational
rd_illegal  out  1  rd_addr unimplemented, combinational
cmt_valid  in  1  instruction present at commit
cmt_pc  in  XLEN  its PC
cmt_cmd  in  3  0 none, 1 RW, 2 RS, 3 RC, 4 MRET
cmt_addr  in  12  CSR target
cmt_wdata  in  XLEN  operand (rs1 or zero-extended uimm, chosen upstream)
cmt_ex  in  1  synchronous exception flagged
cmt_ex_code  in  4  exception cause code
cmt_tval  in  XLEN  fault address/instruction
cmt_retire  in  1  instruction retires normally
stall  in  1  commit frozen this cycle
trint, swint, exint  in  1 each  timer/software/external interrupt lines
hpm_event  in  NUM_HPM (min 1)  per-counter increment strobes
redirect_valid  out  1  redirect fetch
redirect_pc  out  XLEN  redirect target
int_pending  out  1  an enabled interrupt is pending
priv  out  2  current privilege (3 = M, 0 = U)

Behaviour:
- Reset: priv=3, mstatus=0, mie=0, mip=0, mepc=0, mcause=0, mtval=0, mscratch=0, mtvec=RESET_MTVEC, all counters 0, mcountinhibit=0. redirect_valid=0; int_pending=0.
- Accepted ("act") = cmt_valid & !stall. No state change except counters and mip when act=0.
- mip: MTIP(7)/MSIP(3)/MEIP(11) registered from trint/swint/exint every cycle, 1-cycle latency; read-only to software.
- int_pending = mstatus.MIE & |(mie & mip). Priority: MEI (11) > MSI (3) > MTI (7).
- Priority at act: interrupt > exception > MRET > CSR op. Only the highest-priority event takes effect.
- Interrupt:
  - mepc=cmt_pc; mcause={1,code}; mtval=0.
  - Instruction's CSR write is suppressed and it does not retire.
- Exception:
  - mepc=cmt_pc; mcause={0,cmt_ex_code}; mtval=cmt_tval.
- Trap entry (interrupt or exception):
  - MPIE←MIE, MIE←0, MPP←priv, priv←3.
  - Target = mtvec base ({mtvec[XLEN-1:2],00}).
  - If mtvec mode=1 and the trap is an interrupt, target = base + 4*code.
- MRET: MIE←MPIE, MPIE←1, priv←MPP, MPP←0; target=mepc.
- CSR op:
  - old = current register value; new = RW: wdata, RS: old|wdata, RC: old&~wdata; target=cmt_pc+4.
  - Write occurs only if the address is implemented and writable.
  - RS/RC with wdata=0 write nothing (no side effects).
- redirect_valid is asserted the cycle after act for trap, MRET and CSR ops; redirect_pc is held registered for that one cycle.
- Address map:
  - 300 mstatus: only MIE[3], MPIE[7], MPP[12:11] writable; MPP WARL, values 01/10 stored as 00.
  - 301 misa: reads 0, writes ignored.
  - 304 mie: bits 3, 7, 11 only.
  - 305 mtvec: bit1 forced 0; bit0 forced 0 if !VECTORED_EN.
  - 320 mcountinhibit: bits 0, 2, 3..3+NUM_HPM-1.
  - 340 mscratch.
  - 341 mepc: bits[1:0] forced 0.
  - 342 mcause, 343 mtval.
  - 344 mip: read-only, writes ignored.
  - B00 mcycle, B02 minstret, B03+i mhpmcounter(3+i).
  - F14 mhartid: read-only.
  - Any other address: rd_illegal=1, rd_data=0.
- Counters:
  - mcycle +1 every cycle unless inhibit[0].
  - minstret +1 on act & cmt_retire & no trap, unless inhibit[2].
  - hpm i +1 on hpm_event[i] unless inhibit[3+i].
  - All counters wrap modulo 2^XLEN.
  - A CSR write to a counter in the same cycle wins over the increment.
- Read/write same-cycle: rd_data shows the pre-write value; the new value is visible the next cycle.
- Reset asserted mid-trap: reset wins, and redirect_valid is 0 in the following cycle.

Test Plan:
- Reset, read 305/F14/123 -> RESET_MTVEC, HART_ID, rd_illegal=1 with rd_data=0.
- CSRRW 341←0x1003, then CSRRS 300 wdata=0x1888 -> mepc reads 0x1000; mstatus reads 0x1888; write MPP=01 -> reads MPP=00.
- mie=0x880, MIE=1, pulse exint & trint, mtvec=0x8000_0001 -> mcause=0x8000..000B, redirect_pc=0x8000_002C one cycle after act, MIE=0, MPIE=1, priv=3.
- Exception code 2 at pc 0x40 with stall=1 for 2 cycles, then stall=0 -> no change while stalled; then mepc=0x40, mcause=2, mtval=cmt_tval, redirect_pc=mtvec base.
- MRET from MPP=0, MPIE=1 -> priv=0, MIE=1, MPP=0, redirect_pc=mepc.
- mcountinhibit=0x5, 10 retiring commits -> mcycle and minstret frozen; hpm3 counts 10 events; write mcycle=2^XLEN-1 -> wraps to 0 one cycle after inhibit is cleared.
